// File: rtl/tri_bit_packer_pkg.sv
// Shared types and helpers for the serial-to-3-bit-chunk packer that feeds
// the longest-one detector.
package tri_bit_packer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    localparam int CHUNK_W = 3;

    function automatic int ceil_div3(input int n);
        return (n + CHUNK_W - 1) / CHUNK_W;
    endfunction

endpackage

// File: rtl/tri_bit_packer.sv
// Buffers a bit_last-framed serial stream, then replays it as contiguous
// 3-bit chunks (earliest bit in din[2]) followed by a one-cycle len_strobe.
module tri_bit_packer
    import tri_bit_packer_pkg::*;
#(
    parameter int MAX_BITS = 48,
    parameter int DEPTH    = CHUNK_W * ceil_div3(MAX_BITS),
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         bit_last,
    output logic         bit_ready,
    output logic [2:0]   din,
    output logic         count,
    output logic         len_strobe,
    output logic         overflow
);

    localparam logic [CW-1:0] MAX_PTR = CW'(MAX_BITS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_e                state_q, state_d;
    logic [DEPTH-1:0]      buf_q, buf_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         nchunks_q, nchunks_d;
    logic [CW-1:0]         chunk_q, chunk_d;
    logic [CHUNK_W-1:0]    din_q, din_d;
    logic                  count_q, count_d;
    logic                  len_strobe_q, len_strobe_d;
    logic                  overflow_q, overflow_d;
    logic                  xfer;

    // Buffer index 3k is the earliest bit of chunk k and must land in din[2].
    function automatic logic [CHUNK_W-1:0] get_chunk(input logic [DEPTH-1:0] b,
                                                     input logic [CW-1:0]    k);
        logic [CW-1:0]      base;
        logic [CHUNK_W-1:0] raw;
        base = k + k + k;
        raw  = b[base +: CHUNK_W];
        return {raw[0], raw[1], raw[2]};
    endfunction

    assign bit_ready  = (state_q == IDLE) || (state_q == COLLECT);
    assign xfer       = bit_valid && bit_ready;
    assign din        = din_q;
    assign count      = count_q;
    assign len_strobe = len_strobe_q;
    assign overflow   = overflow_q;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        wr_ptr_d     = wr_ptr_q;
        nchunks_d    = nchunks_q;
        chunk_d      = chunk_q;
        overflow_d   = overflow_q;
        din_d        = '0;
        count_d      = 1'b0;
        len_strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    overflow_d = 1'b0;
                    buf_d      = '0;
                    buf_d[0]   = bit_in;
                    wr_ptr_d   = ONE;
                    state_d    = COLLECT;
                    if (bit_last) begin
                        nchunks_d = ONE;
                        chunk_d   = ONE;
                        din_d     = get_chunk(buf_d, '0);
                        count_d   = 1'b1;
                        state_d   = EMIT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (wr_ptr_q == MAX_PTR) begin
                        overflow_d = 1'b1;
                    end else begin
                        buf_d[wr_ptr_q] = bit_in;
                        wr_ptr_d        = wr_ptr_q + ONE;
                    end
                    // Chunk 0 is presented on the same edge that accepts the last bit.
                    if (bit_last) begin
                        nchunks_d = CW'(ceil_div3(int'(wr_ptr_d)));
                        chunk_d   = ONE;
                        din_d     = get_chunk(buf_d, '0);
                        count_d   = 1'b1;
                        state_d   = EMIT;
                    end
                end
            end
            EMIT: begin
                if (chunk_q < nchunks_q) begin
                    din_d   = get_chunk(buf_q, chunk_q);
                    count_d = 1'b1;
                    chunk_d = chunk_q + ONE;
                end else begin
                    len_strobe_d = 1'b1;
                    state_d      = FLUSH;
                end
            end
            FLUSH: begin
                wr_ptr_d  = '0;
                chunk_d   = '0;
                nchunks_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            wr_ptr_q     <= '0;
            nchunks_q    <= '0;
            chunk_q      <= '0;
            din_q        <= '0;
            count_q      <= 1'b0;
            len_strobe_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            wr_ptr_q     <= wr_ptr_d;
            nchunks_q    <= nchunks_d;
            chunk_q      <= chunk_d;
            din_q        <= din_d;
            count_q      <= count_d;
            len_strobe_q <= len_strobe_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_tri_bit_packer.sv
// Bench for tri_bit_packer: a MAX_BITS=48 and a MAX_BITS=6 instance share one
// stimulus stream and are both checked each cycle against a frame-level model.
module tb_tri_bit_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_last = 1'b0;

    logic       ready_a, count_a, strobe_a, ovf_a;
    logic [2:0] din_a;
    logic       ready_b, count_b, strobe_b, ovf_b;
    logic [2:0] din_b;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    tri_bit_packer #(.MAX_BITS(48)) dut_a (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_last(bit_last), .bit_ready(ready_a), .din(din_a), .count(count_a),
        .len_strobe(strobe_a), .overflow(ovf_a)
    );

    tri_bit_packer #(.MAX_BITS(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_last(bit_last), .bit_ready(ready_b), .din(din_b), .count(count_b),
        .len_strobe(strobe_b), .overflow(ovf_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    endtask

    // Frame-level model: stored bits, sticky overflow, and the list of
    // output cycles ({strobe,count,din}) each finished frame must produce.
    int         maxb[2] = '{48, 6};
    logic       mb[2][0:63];
    int         mlen[2] = '{0, 0};
    bit         mfr[2]  = '{0, 0};
    bit         movf[2] = '{0, 0};
    logic [4:0] oq[2][0:63];
    int         oq_wr[2] = '{0, 0};
    int         oq_rd[2] = '{0, 0};
    logic [4:0] cur[2]   = '{5'd0, 5'd0};

    function automatic logic mbit(input int i, input int p);
        return (p < mlen[i]) ? mb[i][p] : 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mlen[i] = 0; mfr[i] = 1'b0; movf[i] = 1'b0;
                oq_wr[i] = 0; oq_rd[i] = 0; cur[i] = 5'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit rdy;
                int n;
                rdy = (cur[i][4:3] == 2'b00);
                if (bit_valid && rdy) begin
                    if (!mfr[i]) begin
                        mfr[i] = 1'b1; mlen[i] = 0; movf[i] = 1'b0;
                    end
                    if (mlen[i] < maxb[i]) begin
                        mb[i][mlen[i]] = bit_in;
                        mlen[i]++;
                    end else begin
                        movf[i] = 1'b1;
                    end
                    if (bit_last) begin
                        n = (mlen[i] + 2) / 3;
                        oq_wr[i] = 0; oq_rd[i] = 0;
                        for (int k = 0; k < n; k++) begin
                            oq[i][oq_wr[i]] = {2'b01, mbit(i, 3*k), mbit(i, 3*k+1), mbit(i, 3*k+2)};
                            oq_wr[i]++;
                        end
                        oq[i][oq_wr[i]] = 5'b10000;
                        oq_wr[i]++;
                        mfr[i] = 1'b0;
                    end
                end
                if (oq_rd[i] < oq_wr[i]) begin
                    cur[i] = oq[i][oq_rd[i]];
                    oq_rd[i]++;
                end else begin
                    cur[i] = 5'd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cycle_a", 32'({ready_a, ovf_a, strobe_a, count_a, din_a}),
                  32'({~|cur[0][4:3], movf[0], cur[0]}));
            check("cycle_b", 32'({ready_b, ovf_b, strobe_b, count_b, din_b}),
                  32'({~|cur[1][4:3], movf[1], cur[1]}));
        end
    end

    // Stand-in for the downstream detector: longest run of ones while count
    // is high, captured when len_strobe fires.
    logic [2:0] din_v[2];
    logic       cnt_v[2];
    logic       stb_v[2];
    int run_l[2] = '{0, 0};
    int best_l[2] = '{0, 0};
    int len_l[2] = '{0, 0};
    assign din_v[0] = din_a;
    assign din_v[1] = din_b;
    assign cnt_v[0] = count_a;
    assign cnt_v[1] = count_b;
    assign stb_v[0] = strobe_a;
    assign stb_v[1] = strobe_b;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cnt_v[i]) begin
                for (int j = 2; j >= 0; j--) begin
                    if (din_v[i][j]) begin
                        run_l[i]++;
                        if (run_l[i] > best_l[i]) best_l[i] = run_l[i];
                    end else begin
                        run_l[i] = 0;
                    end
                end
            end else begin
                if (stb_v[i]) len_l[i] = best_l[i];
                run_l[i] = 0;
                best_l[i] = 0;
            end
        end
    end

    // Holds bit_valid until dut_a accepts the bit; returns 1ns after that edge.
    task automatic send(input logic b, input logic l, input int gap);
        bit r;
        bit done;
        bit_in = b; bit_last = l; bit_valid = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            r = ready_a;
            @(posedge clk);
            if (r) done = 1'b1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        #1;
        bit_valid = 1'b0; bit_last = 1'b0; bit_in = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        started = 1'b1;
        check("rst_ready", 32'(ready_a), 1);
        check("rst_outs", 32'({count_a, strobe_a, ovf_a, din_a}), 0);
        check("rst_outs_b", 32'({ready_b, count_b, strobe_b, ovf_b, din_b}), 32'h40);
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // 1,1,1,0,1 -> 111, 010, strobe; detector length 3
        send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 0);
        @(negedge clk);
        check("f1_c0", 32'({count_a, din_a}), 32'b1111);
        check("f1_busy", 32'(ready_a), 0);
        @(negedge clk);
        check("f1_c1", 32'({count_a, din_a}), 32'b1010);
        @(negedge clk);
        check("f1_strobe", 32'({strobe_a, count_a, din_a}), 32'b10000);
        idle(2);
        check("f1_len", 32'(len_l[0]), 3);

        // single bit
        send(1, 1, 0);
        @(negedge clk);
        check("f2_c0", 32'({count_a, din_a}), 32'b1100);
        @(negedge clk);
        check("f2_strobe", 32'({strobe_a, count_a}), 32'b10);
        idle(2);

        // 0,1,1,1,1,0 with 2-cycle gaps
        send(0, 0, 2); send(1, 0, 2); send(1, 0, 2); send(1, 0, 2); send(1, 0, 2); send(0, 1, 0);
        @(negedge clk);
        check("f3_c0", 32'({count_a, din_a}), 32'b1011);
        @(negedge clk);
        check("f3_c1", 32'({count_a, din_a}), 32'b1110);
        idle(3);
        check("f3_len", 32'(len_l[0]), 4);

        // 8 ones: overflows the 6-bit instance only
        for (int k = 0; k < 8; k++) send(1, (k == 7), 0);
        idle(6);
        check("f4_ovf_b", 32'(ovf_b), 1);
        check("f4_ovf_a", 32'(ovf_a), 0);
        check("f4_len_b", 32'(len_l[1]), 6);
        check("f4_len_a", 32'(len_l[0]), 8);

        // next frame clears overflow; valid held through EMIT/FLUSH
        send(1, 0, 0);
        check("f5_ovf_clr", 32'(ovf_b), 0);
        send(0, 0, 0); send(1, 1, 0);
        bit_in = 1'b0; bit_valid = 1'b1;
        @(negedge clk);
        check("f5_hold_c0", 32'({ready_a, ready_b, count_a, din_a}), 32'b001101);
        @(negedge clk);
        check("f5_hold_fl", 32'({ready_a, strobe_a}), 32'b01);
        send(0, 0, 0); send(1, 1, 0);
        @(negedge clk);
        check("f6_c0", 32'({count_a, din_a}), 32'b1010);
        idle(3);
        check("f6_len", 32'(len_l[0]), 1);

        // reset during the second chunk of a 9-bit frame
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
        send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
        send(0, 0, 0); send(1, 0, 0); send(1, 1, 0);
        @(posedge clk);
        #1;
        check("f7_c1", 32'({count_a, din_a}), 32'b1110);
        rst_n = 1'b0;
        #1;
        check("f7_rst", 32'({ready_a, count_a, strobe_a, din_a}), 32'b100000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        check("f7_nolen", 32'(len_l[0]), 1);

        // normal frame after reset
        send(1, 0, 0); send(1, 0, 0); send(0, 1, 0);
        @(negedge clk);
        check("f8_c0", 32'({count_a, din_a}), 32'b1110);
        idle(3);
        check("f8_len", 32'(len_l[0]), 2);

        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tri_bit_packer.md
Name: tri_bit_packer

Overview:
- Upstream feeder for the longest-one detector. Accepts a serial bit stream framed by bit_last and buffers the whole frame.
- Replays the frame as back-to-back 3-bit chunks on din with count held high, because the detector restarts its run tracking whenever count drops.
- Drops count for one cycle after the last chunk and pulses len_strobe, so the downstream stage captures the detector's final length before it clears.

Parameters:
- MAX_BITS, 48: maximum frame length in bits.
- DEPTH, 3*ceil(MAX_BITS/3): buffer size in bits (derived; do not override).
- CW, $clog2(DEPTH+1): width of the bit and chunk counters (derived).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous, active-low
- bit_in  in  1  serial data bit
- bit_valid  in  1  bit_in is valid this cycle
- bit_last  in  1  final bit of the frame; qualified by bit_valid
- bit_ready  out  1  packer accepts bits; a bit transfers when bit_valid && bit_ready
- din  out  3  chunk to detector; din[2] is the earliest bit
- count  out  1  chunk on din is valid; high for exactly the chunks of one frame, contiguous
- len_strobe  out  1  one-cycle pulse; detector length is final this cycle
- overflow  out  1  sticky; frame exceeded MAX_BITS

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, all buffer bits 0, counters 0.
  - din=0, count=0, len_strobe=0, overflow=0, bit_ready=1.
  - Reset mid-EMIT: count falls immediately; that frame is lost.
- All outputs are registered except bit_ready, which is decoded from state.
- Frame start: the first transfer in IDLE. Transition IDLE->COLLECT, clear overflow, clear the buffer, write the bit at index 0, wr_ptr=1.
  - If bit_last is set on that transfer, go straight to EMIT.
- COLLECT:
  - bit_ready=1.
  - Each transfer writes buf[wr_ptr] and increments wr_ptr.
  - Once wr_ptr==MAX_BITS, further bits are discarded and overflow=1. wr_ptr saturates.
  - Gaps in bit_valid: hold state; outputs unchanged (count=0).
  - A transfer with bit_last: latch nchunks=ceil(wr_ptr_after/3), then go to EMIT next cycle.
- EMIT:
  - bit_ready=0.
  - For chunk k=0..nchunks-1 on consecutive cycles: din = {buf[3k], buf[3k+1], buf[3k+2]} with count=1.
  - Unwritten positions in the final chunk read as 0 (zero padding).
  - After the last chunk go to FLUSH.
- FLUSH (1 cycle):
  - count=0, din=0, len_strobe=1, bit_ready=0. Then go to IDLE.
- Latency:
  - The transfer with bit_last at edge t produces the first chunk with count=1 in cycle t+1.
  - len_strobe fires in cycle t+1+nchunks.
- Bit ordering: the first received bit lands in din[2] of chunk 0.
- Simultaneous events: bit_valid during EMIT/FLUSH is ignored (not accepted); the upstream source must hold the bit.
- A frame always holds at least 1 bit. bit_last on an overflowed frame still ends the frame; MAX_BITS bits are emitted.

Decomposition:
- Shared package contains:
  - state enum {IDLE, COLLECT, EMIT, FLUSH}
  - CHUNK_W=3
  - ceil-div-by-3 function used for DEPTH and nchunks
- Single module; no sub-module is required. The buffer is a flat DEPTH-bit register with indexed write and 3-bit indexed read.

Test Plan:
- Bits 1,1,1,0,1 (last on 5th) -> count=1 for 2 cycles, din=111 then 010; then len_strobe=1 with count=0; detector length=3.
- Single bit 1 with bit_last -> exactly one cycle din=100, count=1; next cycle len_strobe=1.
- Bits 0,1,1 | 1,1,0 with bit_valid gaps of 2 cycles between bits -> count stays 0 during COLLECT; emits 011, 110 back-to-back; detector length=4.
- MAX_BITS=6, 8 bits all 1 -> overflow=1, 2 chunks 111, 111; detector length=6; overflow clears on the next frame's first transfer.
- bit_valid held high through EMIT/FLUSH of frame 1 -> bit_ready=0, no bits consumed; frame 2 starts in IDLE and its chunk 0 holds frame 2's first bit.
- rst_n low for 1 cycle during the second chunk of a 9-bit frame -> count=0 and din=0 immediately, state IDLE, no len_strobe; the next frame proceeds normally.
